// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// Sizes match the 16-entry instruction memory and 32-bit ARM instruction words.
package cpu_pkg;

  localparam int PC_WIDTH    = 4;
  localparam int INSTR_WIDTH = 32;
  localparam logic [31:0] HALT_WORD = 32'hEF00_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target for an ARM-style relative branch: IR_PC + 2 + sext(imm24), in words.
// The result wraps modulo the fetch address space.
module branch_target_calc #(
  parameter int PC_WIDTH = cpu_pkg::PC_WIDTH
) (
  input  logic [PC_WIDTH-1:0] ir_pc,
  input  logic [23:0]         imm,
  output logic [PC_WIDTH-1:0] target
);

  logic [23:0] sum_s;
  logic        unused_sum_hi_s;

  // Low PC_WIDTH bits of a 24-bit sum equal the sign-extended sum truncated to PC_WIDTH.
  assign sum_s           = {{(24-PC_WIDTH){1'b0}}, ir_pc} + 24'd2 + imm;
  assign target          = sum_s[PC_WIDTH-1:0];
  assign unused_sum_hi_s = ^sum_s[23:PC_WIDTH];

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, latches the memory word into IR for decode, handles
// branch redirect with wrong-path squash, start gating and halt on a sentinel word.
module fetch_stage #(
  parameter int                    PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int                    INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD  = cpu_pkg::HALT_WORD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_in,
  input  logic [INSTR_WIDTH-1:0] IR_in,
  input  logic                   decode_ready_in,
  input  logic                   branch_taken_in,
  input  logic [23:0]            branch_imm_in,
  output logic [PC_WIDTH-1:0]    PC_out,
  output logic [INSTR_WIDTH-1:0] IR_out,
  output logic [PC_WIDTH-1:0]    IR_PC_out,
  output logic                   IR_valid_out,
  output logic                   halted_out
);

  import cpu_pkg::*;

  fetch_state_t           state_r, state_n;
  logic [PC_WIDTH-1:0]    pc_r, pc_n;
  logic [INSTR_WIDTH-1:0] ir_r, ir_n;
  logic [PC_WIDTH-1:0]    ir_pc_r, ir_pc_n;
  logic                   valid_r, valid_n;
  logic                   halted_r;
  logic                   branch_s;
  logic                   advance_s;
  logic [PC_WIDTH-1:0]    target_s;

  branch_target_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_target (
    .ir_pc  (ir_pc_r),
    .imm    (branch_imm_in),
    .target (target_s)
  );

  // Next-state: branch beats capture/stall, and a branch also squashes halt detection on IR_in.
  always_comb begin
    state_n   = state_r;
    pc_n      = pc_r;
    ir_n      = ir_r;
    ir_pc_n   = ir_pc_r;
    valid_n   = valid_r;
    branch_s  = branch_taken_in && valid_r && (state_r != IDLE);
    advance_s = (state_r == RUN) && (!valid_r || decode_ready_in);

    if (branch_s) begin
      pc_n    = target_s;
      valid_n = 1'b0;
      state_n = RUN;
    end else if (advance_s) begin
      if (IR_in == HALT_WORD) begin
        valid_n = 1'b0;
        state_n = HALT;
      end else begin
        ir_n    = IR_in;
        ir_pc_n = pc_r;
        valid_n = 1'b1;
        pc_n    = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (start_in) begin
            state_n = RUN;
          end else begin
            state_n = IDLE;
          end
        end
        RUN:     state_n = RUN;
        HALT:    state_n = HALT;
        default: state_n = IDLE;
      endcase
    end
  end

  // State, PC and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      ir_r     <= '0;
      ir_pc_r  <= '0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      pc_r     <= pc_n;
      ir_r     <= ir_n;
      ir_pc_r  <= ir_pc_n;
      valid_r  <= valid_n;
      halted_r <= (state_n == HALT);
    end
  end

  assign PC_out       = pc_r;
  assign IR_out       = ir_r;
  assign IR_PC_out    = ir_pc_r;
  assign IR_valid_out = valid_r;
  assign halted_out   = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IR/IR_PC pairs are queued by the
// stimulus and checked by a monitor on every decode handshake.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  logic [31:0] IR_in;
  logic        decode_ready_in;
  logic        branch_taken_in;
  logic [23:0] branch_imm_in;
  logic [3:0]  PC_out;
  logic [31:0] IR_out;
  logic [3:0]  IR_PC_out;
  logic        IR_valid_out;
  logic        halted_out;

  logic [31:0] mem [16];

  typedef struct packed {
    logic [31:0] ir;
    logic [3:0]  pc;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  localparam logic [31:0] HALT_W = 32'hEF00_0000;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_in        (start_in),
    .IR_in           (IR_in),
    .decode_ready_in (decode_ready_in),
    .branch_taken_in (branch_taken_in),
    .branch_imm_in   (branch_imm_in),
    .PC_out          (PC_out),
    .IR_out          (IR_out),
    .IR_PC_out       (IR_PC_out),
    .IR_valid_out    (IR_valid_out),
    .halted_out      (halted_out)
  );

  assign IR_in = mem[PC_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && IR_valid_out && decode_ready_in) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL sb_unexpected: got pc %0d ir %h expected nothing", IR_PC_out, IR_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ir_pc", {28'd0, IR_PC_out}, {28'd0, e.pc});
        check("sb_ir", IR_out, e.ir);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem(input logic [31:0] w8, input logic [31:0] w9);
    for (int i = 0; i < 16; i++) mem[i] = 32'hE280_0000 | 32'(i);
    mem[0] = 32'hE3A1_1016;
    mem[1] = 32'hE3A0_2005;
    mem[2] = 32'hE3A0_3007;
    mem[3] = 32'hE081_4002;
    mem[8] = w8;
    mem[9] = w9;
  endtask

  task automatic push(input int a);
    exp_t e;
    e.ir = mem[a];
    e.pc = 4'(a);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    start_in        = 1'b0;
    decode_ready_in = 1'b1;
    branch_taken_in = 1'b0;
    branch_imm_in   = 24'd0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", {28'd0, PC_out}, 32'd0);
    check("rst_ir", IR_out, 32'd0);
    check("rst_valid", {31'd0, IR_valid_out}, 32'd0);
    check("rst_halted", {31'd0, halted_out}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_irpc(input logic [3:0] a, input string name);
    for (int n = 0; n < 40; n++) begin
      step();
      if (IR_valid_out && IR_PC_out == a) return;
    end
    tests++;
    failed++;
    $display("FAIL %s: timeout waiting for IR_PC_out=%0d, got %0d", name, a, IR_PC_out);
  endtask

  initial begin
    rst_n = 1'b0;

    // Sequential fetch, stall, branch forward, wrap, branch backward.
    load_mem(32'hE280_0008, 32'hE280_0009);
    do_reset();
    for (int a = 0; a < 8; a++) push(a);
    push(13); push(14); push(15); push(0); push(1); push(0);
    repeat (3) step();
    check("idle_pc", {28'd0, PC_out}, 32'd0);
    check("idle_valid", {31'd0, IR_valid_out}, 32'd0);
    start_in = 1'b1;
    wait_irpc(4'd2, "seq_to_2");
    decode_ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_irpc", {28'd0, IR_PC_out}, 32'd2);
      check("stall_pc", {28'd0, PC_out}, 32'd3);
      check("stall_ir", IR_out, 32'hE3A0_3007);
    end
    decode_ready_in = 1'b1;
    step();
    check("resume_irpc", {28'd0, IR_PC_out}, 32'd3);
    wait_irpc(4'd7, "seq_to_7");
    branch_taken_in = 1'b1;
    branch_imm_in   = 24'd4;
    step();
    branch_taken_in = 1'b0;
    check("br_fwd_pc", {28'd0, PC_out}, 32'd13);
    check("br_fwd_valid", {31'd0, IR_valid_out}, 32'd0);
    step();
    check("br_fwd_irpc", {28'd0, IR_PC_out}, 32'd13);
    check("br_fwd_valid2", {31'd0, IR_valid_out}, 32'd1);
    wait_irpc(4'd15, "seq_to_15");
    check("wrap_pc", {28'd0, PC_out}, 32'd0);
    wait_irpc(4'd1, "wrap_to_1");
    branch_taken_in = 1'b1;
    branch_imm_in   = 24'hFF_FFFD;
    step();
    branch_taken_in = 1'b0;
    check("br_back_pc", {28'd0, PC_out}, 32'd0);
    check("br_back_valid", {31'd0, IR_valid_out}, 32'd0);
    step();
    check("br_back_irpc", {28'd0, IR_PC_out}, 32'd0);
    check("br_back_next_pc", {28'd0, PC_out}, 32'd1);
    step();
    decode_ready_in = 1'b0;
    check("run1_drain", 32'(sb.size()), 32'd0);

    // Halt word at address 9 stops the stage without reaching decode.
    load_mem(32'hE280_0008, HALT_W);
    do_reset();
    for (int a = 0; a < 9; a++) push(a);
    start_in = 1'b1;
    begin
      int n;
      n = 0;
      while (!halted_out && n < 40) begin
        step();
        n++;
      end
    end
    check("halt_flag", {31'd0, halted_out}, 32'd1);
    check("halt_valid", {31'd0, IR_valid_out}, 32'd0);
    check("halt_pc", {28'd0, PC_out}, 32'd9);
    repeat (3) step();
    check("halt_hold_pc", {28'd0, PC_out}, 32'd9);
    check("halt_hold_flag", {31'd0, halted_out}, 32'd1);
    check("halt_drain", 32'(sb.size()), 32'd0);

    // Taken branch at 8 squashes the halt word fetched in the same cycle.
    load_mem(32'hEA00_0001, HALT_W);
    do_reset();
    for (int a = 0; a < 9; a++) push(a);
    start_in = 1'b1;
    wait_irpc(4'd8, "seq_to_8");
    branch_taken_in = 1'b1;
    branch_imm_in   = 24'd1;
    step();
    branch_taken_in = 1'b0;
    check("squash_halted", {31'd0, halted_out}, 32'd0);
    check("squash_pc", {28'd0, PC_out}, 32'd11);
    check("squash_valid", {31'd0, IR_valid_out}, 32'd0);
    step();
    decode_ready_in = 1'b0;
    check("squash_irpc", {28'd0, IR_PC_out}, 32'd11);
    check("squash_ir", IR_out, 32'hE280_000B);
    check("squash_halted2", {31'd0, halted_out}, 32'd0);
    check("squash_drain", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of a stall.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", {28'd0, PC_out}, 32'd0);
    check("async_ir", IR_out, 32'd0);
    check("async_irpc", {28'd0, IR_PC_out}, 32'd0);
    check("async_valid", {31'd0, IR_valid_out}, 32'd0);
    check("async_halted", {31'd0, halted_out}, 32'd0);
    start_in        = 1'b0;
    decode_ready_in = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_idle_pc", {28'd0, PC_out}, 32'd0);
    check("post_rst_idle_valid", {31'd0, IR_valid_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
